// File: rtl/ysyx_23060042_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide unit.
package ysyx_23060042_pkg;

  localparam int MDU_STEPS = 32;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mdu_state_e;

  // MUL only keeps the low half, so its operand signedness is irrelevant
  function automatic logic op_a_signed(mdu_op_e op);
    return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  function automatic logic op_b_signed(mdu_op_e op);
    return op inside {OP_MULH, OP_DIV, OP_REM};
  endfunction

endpackage

// File: rtl/ysyx_23060042_mdu_negate.sv
// Conditional two's-complement: y = en ? -a : a.
module ysyx_23060042_mdu_negate #(
  parameter int XLEN = 32
) (
  input  logic            en,
  input  logic [XLEN-1:0] a,
  output logic [XLEN-1:0] y
);

  assign y = en ? (~a + XLEN'(1)) : a;

endmodule

// File: rtl/ysyx_23060042_mdu.sv
// Iterative RV32M unit: shift-add multiply / restoring divide on magnitudes,
// one radix-2 step per cycle, sign fixed up on the last step.
module ysyx_23060042_mdu
  import ysyx_23060042_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      MduOp,
  input  logic [XLEN-1:0] data1,
  input  logic [XLEN-1:0] data2,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out
);

  localparam int CW = $clog2(MDU_STEPS);

  mdu_state_e          state, state_nxt;
  logic [CW-1:0]       cnt;
  mdu_op_e             op;
  logic                neg_res;
  logic [2*XLEN-1:0]   prod;   // hi: partial product; lo: multiplier or dividend/quotient
  logic [XLEN-1:0]     mcand;  // multiplicand or divisor magnitude
  logic [XLEN-1:0]     rem;
  logic [XLEN-1:0]     res;

  mdu_op_e   op_in;
  logic      a_neg, b_neg, accept, step, last;
  logic      div_zero, div_ovf, special;
  logic [XLEN-1:0] a_abs, b_abs, special_res;

  assign op_in  = mdu_op_e'(MduOp);
  assign a_neg  = op_a_signed(op_in) & data1[XLEN-1];
  assign b_neg  = op_b_signed(op_in) & data2[XLEN-1];
  assign accept = (state == IDLE) && in_valid && !flush;
  assign step   = (state == BUSY) && !flush;
  assign last   = step && (cnt == '0);

  ysyx_23060042_mdu_negate #(.XLEN(XLEN)) u_abs_a (.en(a_neg), .a(data1), .y(a_abs));
  ysyx_23060042_mdu_negate #(.XLEN(XLEN)) u_abs_b (.en(b_neg), .a(data2), .y(b_abs));

  assign div_zero = op_in[2] && (data2 == '0);
  assign div_ovf  = (op_in == OP_DIV || op_in == OP_REM) &&
                    (data1 == {1'b1, {(XLEN-1){1'b0}}}) && (data2 == '1);
  assign special  = div_zero || div_ovf;

  // op[1] separates REM/REMU from DIV/DIVU
  always_comb begin
    special_res = '0;
    if (div_zero)  special_res = op_in[1] ? data1 : '1;
    else           special_res = op_in[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
  end

  // one datapath step
  logic [XLEN:0]     add_sum, rem_sh;
  logic [2*XLEN-1:0] mul_nxt;
  logic [XLEN-1:0]   quo_nxt, rem_nxt;
  logic              rem_ge;

  assign add_sum = {1'b0, prod[2*XLEN-1:XLEN]} + (prod[0] ? {1'b0, mcand} : '0);
  assign mul_nxt = {add_sum, prod[XLEN-1:1]};
  assign rem_sh  = {rem, prod[XLEN-1]};
  assign rem_ge  = rem_sh >= {1'b0, mcand};
  assign rem_nxt = rem_ge ? XLEN'(rem_sh - {1'b0, mcand}) : rem_sh[XLEN-1:0];
  assign quo_nxt = {prod[XLEN-2:0], rem_ge};

  // sign correction of the finished result
  logic [XLEN-1:0] lo_raw, lo_fix, hi_neg, hi_fix, step_res;

  always_comb begin
    lo_raw = rem_nxt;
    if (op == OP_MUL)                        lo_raw = mul_nxt[XLEN-1:0];
    else if (op == OP_DIV || op == OP_DIVU)  lo_raw = quo_nxt;
  end

  ysyx_23060042_mdu_negate #(.XLEN(XLEN)) u_neg_lo (.en(neg_res), .a(lo_raw), .y(lo_fix));
  ysyx_23060042_mdu_negate #(.XLEN(XLEN)) u_neg_hi (.en(neg_res), .a(mul_nxt[2*XLEN-1:XLEN]), .y(hi_neg));

  // high half of -P only gets the +1 carry when the low half is zero
  assign hi_fix   = (neg_res && mul_nxt[XLEN-1:0] != '0) ? ~mul_nxt[2*XLEN-1:XLEN] : hi_neg;
  assign step_res = (op inside {OP_MULH, OP_MULHSU, OP_MULHU}) ? hi_fix : lo_fix;

  always_comb begin
    state_nxt = state;
    if (flush) state_nxt = IDLE;
    else begin
      case (state)
        IDLE:    if (in_valid) state_nxt = special ? DONE : BUSY;
        BUSY:    if (cnt == '0) state_nxt = DONE;
        DONE:    if (out_ready) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      op      <= OP_MUL;
      neg_res <= 1'b0;
      prod    <= '0;
      mcand   <= '0;
      rem     <= '0;
      res     <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op      <= op_in;
        neg_res <= op_in[1] && op_in[2] ? a_neg : (a_neg ^ b_neg);
        rem     <= '0;
        if (special) begin
          res <= special_res;
          cnt <= '0;
        end else begin
          prod  <= {{XLEN{1'b0}}, a_abs};
          mcand <= b_abs;
          cnt   <= CW'(MDU_STEPS - 1);
        end
      end else if (step) begin
        if (op[2]) begin
          prod[XLEN-1:0] <= quo_nxt;
          rem            <= rem_nxt;
        end else begin
          prod <= mul_nxt;
        end
        if (last) res <= step_res;
        else      cnt <= cnt - CW'(1);
      end
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign out       = res;

endmodule

// File: tb/tb_ysyx_23060042_mdu.sv
// Directed-vector bench for ysyx_23060042_mdu.
module tb_ysyx_23060042_mdu;
  import ysyx_23060042_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  MduOp = '0;
  logic [31:0] data1 = '0;
  logic [31:0] data2 = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  ysyx_23060042_mdu #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .MduOp(MduOp), .data1(data1), .data2(data2), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out(out)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // present for one edge, then scramble inputs to prove capture-at-accept
  task automatic issue(input mdu_op_e op, input logic [31:0] a, input logic [31:0] b);
    MduOp = op; data1 = a; data2 = b; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    MduOp = ~MduOp; data1 = ~a; data2 = $urandom;
  endtask

  task automatic wait_valid(output int lat);
    lat = 1;
    while (!out_valid && lat < 100) begin
      step();
      lat++;
    end
  endtask

  task automatic run(input string tag, input mdu_op_e op, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int lat;
    chk({tag, " in_ready"}, {31'b0, in_ready}, 32'd1);
    issue(op, a, b);
    wait_valid(lat);
    chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
    chk(tag, out, exp);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, " idle"}, {30'b0, in_ready, out_valid}, 32'b10);
  endtask

  initial begin
    int lat;
    logic seen;

    repeat (2) step();
    chk("reset in_ready", {31'b0, in_ready}, 32'd1);
    chk("reset out_valid", {31'b0, out_valid}, 32'd0);
    chk("reset out", out, 32'd0);
    rst_n = 1'b1;
    step();

    run("MUL",    OP_MUL,    32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 33);
    run("MULH",   OP_MULH,   32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 33);
    run("MULHU",  OP_MULHU,  32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 33);
    run("MULHSU", OP_MULHSU, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 33);
    run("MULH big", OP_MULH, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33);
    run("DIV",    OP_DIV,    32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
    run("REM",    OP_REM,    32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
    run("DIVU",   OP_DIVU,   32'd7,         32'd2, 32'd3,         33);
    run("REMU",   OP_REMU,   32'd7,         32'd2, 32'd1,         33);
    run("DIVU /0",   OP_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    run("REM /0",    OP_REM,  32'd5, 32'd0, 32'd5,         1);
    run("DIV ovf",   OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run("REM ovf",   OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1);

    // back-pressure: result and handshake must hold
    issue(OP_DIVU, 32'd7, 32'd2);
    wait_valid(lat);
    chk("bp latency", 32'(lat), 32'd33);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("bp out", out, 32'd3);
      chk("bp valid/ready", {30'b0, out_valid, in_ready}, 32'b10);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("bp release", {30'b0, in_ready, out_valid}, 32'b10);

    // request together with flush is dropped
    MduOp = OP_MUL; data1 = 32'd9; data2 = 32'd9; in_valid = 1'b1; flush = 1'b1;
    step();
    in_valid = 1'b0; flush = 1'b0;
    chk("flush+req dropped", {30'b0, in_ready, out_valid}, 32'b10);

    // flush at BUSY cycle 15
    issue(OP_MUL, 32'd5, 32'd6);
    repeat (14) step();
    chk("pre-flush busy", {31'b0, in_ready}, 32'd0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush idle", {30'b0, in_ready, out_valid}, 32'b10);
    seen = 1'b0;
    repeat (40) begin
      step();
      seen |= out_valid;
    end
    chk("flush no valid", {31'b0, seen}, 32'd0);
    run("MUL after flush", OP_MUL, 32'd3, 32'd4, 32'd12, 33);

    // reset at BUSY cycle 20
    issue(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (19) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("midrst out_valid", {31'b0, out_valid}, 32'd0);
    chk("midrst in_ready", {31'b0, in_ready}, 32'd1);
    chk("midrst out", out, 32'd0);
    run("DIVU after reset", OP_DIVU, 32'd100, 32'd7, 32'd14, 33);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ysyx_23060042_mdu.md
# ysyx_23060042_mdu

Iterative RV32M multiply/divide unit in the execute stage, beside the single-cycle integer ALU. The ALU covers add/sub/shift/logic/compare in one cycle. This block takes the eight M-extension operations through a valid/ready request port. It returns the 32-bit result through a valid/ready response port after a fixed multi-cycle latency. The decode stage selects it through funct3; writeback stalls on the response handshake.

## Interface
Parameters:
- XLEN, 32, operand/result width; only 32 is supported.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  request present.
- in_ready  out  1  unit can accept a request.
- MduOp  in  3  funct3 encoding, mapped as follows:
  - 000 MUL
  - 001 MULH
  - 010 MULHSU
  - 011 MULHU
  - 100 DIV
  - 101 DIVU
  - 110 REM
  - 111 REMU
- data1  in  XLEN  rs1 operand.
- data2  in  XLEN  rs2 operand.
- flush  in  1  abort any in-flight operation; takes priority over everything except reset.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes result.
- out  out  XLEN  result.

## Operation
- States and transitions:
  - IDLE: in_ready=1. On in_valid, latch the op, operands and sign info.
    - Special division case: go to DONE.
    - Otherwise go to BUSY with cnt=31.
  - BUSY: run one radix-2 step per cycle. When a step completes with cnt==0, go to DONE; otherwise decrement cnt.
  - DONE: out_valid=1 and out holds the result. If out_ready is high, go to IDLE.
- Multiply: shift-add on absolute values with a 64-bit product register. The final sign correction is by two's-complement negation when the operand signs differ.
  - MUL returns product[31:0].
  - MULH, MULHSU and MULHU return product[63:32].
  - For MULHSU, only data1 is treated as signed.
- Divide: restoring division on absolute values with a 33-bit partial remainder.
  - The quotient sign is data1 sign XOR data2 sign.
  - The remainder sign equals the data1 sign.
  - Signed handling applies only to DIV and REM.
- Special cases, resolved in IDLE with no BUSY cycles:
  - Divide by zero: DIV/DIVU returns 0xFFFFFFFF; REM/REMU returns data1.
  - Signed overflow (data1=0x80000000, data2=0xFFFFFFFF, DIV/REM): DIV returns 0x80000000; REM returns 0.
- All arithmetic is modulo 2^XLEN. No exceptions and no flags.
- flush:
  - In any state, the next state is IDLE and out_valid is 0 from the next cycle.
  - A request with in_valid and flush in the same cycle is not accepted.
- Operands are captured at acceptance. data1, data2 and MduOp may change afterwards with no effect.

## Timing
- Reset values:
  - state=IDLE, in_ready=1, out_valid=0, out=0, cnt=0.
  - All internal registers are 0.
- in_ready is 1 only in IDLE. It is a registered-state decode, not combinationally dependent on in_valid.
- Latency, with the request accepted at edge t:
  - Normal op: BUSY in cycles t+1 … t+32; out_valid rises in cycle t+33 (33-cycle latency).
  - Special case: out_valid in cycle t+1.
- Response handshake:
  - out and out_valid stay stable while out_valid=1 and out_ready=0.
  - Holding for an arbitrary number of cycles is required.
- Throughput:
  - A transfer at edge u returns to IDLE; the next request can be accepted at edge u+1.
  - There is no same-cycle done-and-accept.
- Reset mid-operation (rst_n low at any edge): all outputs return to reset values at that edge. Partial results are discarded.

## Structure
- The shared package ysyx_23060042_pkg holds:
  - the mdu_op_e enum (the eight MduOp codes above);
  - the mdu_state_e enum (IDLE, BUSY, DONE);
  - the constant MDU_STEPS=32.
- Sub-module ysyx_23060042_mdu_negate: XLEN-bit conditional two's-complement unit. It is instantiated for operand absolute values and for result sign correction.
- The control FSM and the datapath registers stay in the top module.

## Test plan
- MUL 0xFFFFFFFF×0x00000002:
  - MUL → out 0xFFFFFFFE, out_valid exactly 33 cycles after acceptance.
  - MULH → 0xFFFFFFFF.
  - MULHU → 0x00000001.
  - MULHSU (data1=0xFFFFFFFF, data2=2) → 0xFFFFFFFF.
- DIV −7/2 → 0xFFFFFFFD. REM −7/2 → 0xFFFFFFFF. DIVU 7/2 → 3. REMU 7/2 → 1.
- Division specials, each with out_valid one cycle after acceptance:
  - DIVU 5/0 → 0xFFFFFFFF.
  - REM 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000.
  - REM of the same operands → 0.
- Back-pressure: hold out_ready=0 for 10 cycles after out_valid.
  - out, out_valid and in_ready=0 stay stable throughout.
  - Raising out_ready transfers; in_ready returns the next cycle.
- Flush at BUSY cycle 15 → out_valid never asserts, and the unit is in IDLE next cycle. A new MUL 3×4 then returns 12.
- rst_n low for one edge at BUSY cycle 20 → out_valid=0, in_ready=1, out=0. A subsequent DIVU 100/7 returns 14.
